// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with range check
//
// Purpose: shares one single-cycle data memory between the pipeline MEM
// stage (port 0) and a DMA/debug master (port 1). One transaction runs at
// a time through IDLE -> ACCESS (-> RESP for reads).
//
// Configuration macro: DMEM_ARB_RR_EN
//   defined   : round-robin arbitration between the two ports
//   undefined : fixed priority, port 0 wins
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   pN_req, pN_we                request, 1 = write / 0 = read
//   pN_addr, pN_wdata            word address and write data (held until gnt)
//   pN_gnt                       one-cycle accept pulse
//   pN_err                       one-cycle out-of-range pulse (with gnt)
//   pN_rvalid, pN_rdata          read response; rdata holds until next read
//   memread, memwrite            data-memory strobes (ACCESS cycle only)
//   address, writedata           data-memory address and write data
//   readdata                     data-memory read data, valid with memread
module dmem_arbiter #(
  parameter int ADDR_LIMIT = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] address,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic        lat_we;
  logic        lat_port;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        any_req;
  logic        win;
  logic        addr_err;

  assign any_req  = p0_req | p1_req;
  assign addr_err = (lat_addr >= 32'(ADDR_LIMIT));

  // Memory-side address/data come straight from the transaction registers,
  // so they read 0 after reset and are stable for the whole ACCESS cycle.
  assign address   = lat_addr;
  assign writedata = lat_wdata;

`ifdef DMEM_ARB_RR_EN
  // rr_prio names the port that wins a tie; it flips to the other port on
  // every grant, error grants included.
  logic rr_prio;

  always_comb begin
    win = p1_req;
    if (p0_req && p1_req) begin
      win = rr_prio;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_prio <= 1'b0;
    end else if (state == ACCESS) begin
      rr_prio <= ~lat_port;
    end
  end
`else
  // Port 1 only wins when port 0 is not requesting.
  assign win = ~p0_req;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_port  <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      p0_rdata  <= 32'h0;
      p1_rdata  <= 32'h0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_req) begin
        lat_port  <= win;
        lat_we    <= win ? p1_we    : p0_we;
        lat_addr  <= win ? p1_addr  : p0_addr;
        lat_wdata <= win ? p1_wdata : p0_wdata;
      end
      if (state == ACCESS && !lat_we && !addr_err) begin
        if (lat_port) begin
          p1_rdata <= readdata;
        end else begin
          p0_rdata <= readdata;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    p0_gnt     = 1'b0;
    p1_gnt     = 1'b0;
    p0_err     = 1'b0;
    p1_err     = 1'b0;
    p0_rvalid  = 1'b0;
    p1_rvalid  = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        p0_gnt = ~lat_port;
        p1_gnt = lat_port;
        if (addr_err) begin
          p0_err     = ~lat_port;
          p1_err     = lat_port;
          state_next = IDLE;
        end else if (lat_we) begin
          memwrite   = 1'b1;
          state_next = IDLE;
        end else begin
          memread    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        p0_rvalid  = ~lat_port;
        p1_rvalid  = lat_port;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
